int_add_issue_queue: RTL and testbench
======================================

Name: int_add_issue_queue

Overview:
- Issue stage directly upstream of the integer adder.
- Accepts RV32I instructions with their register-file operands from decode and decodes ADD/SUB/ADDI into adder control, operands and immediate.
- Buffers the decoded ops in a small FIFO and presents the head op to the adder under a valid/ready handshake.
- Tracks the destination register alongside the adder's one-cycle registered result, so writeback gets an aligned valid/rd pair.

Parameters:
- DATA_WIDTH, 32, operand width; equals the system data width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RD_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush; clears queue and writeback tag.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  raw instruction word.
- in_rs1_data  in  DATA_WIDTH  rs1 operand value.
- in_rs2_data  in  DATA_WIDTH  rs2 operand value.
- dec_illegal  out  1  one-cycle pulse: accepted handshake carried a non-ADD/SUB/ADDI instruction.
- out_valid  out  1  head op valid.
- out_ready  in  1  adder accepts the head op.
- add_type  out  2  00 ADD, 01 SUB, 10 ADDI (the CTRL_ADD/CTRL_SUB/CTRL_ADDI codes).
- src1  out  DATA_WIDTH  head rs1 value.
- src2  out  DATA_WIDTH  head rs2 value; 0 for ADDI.
- immediate  out  21  sign-extended I-immediate, imm[11] replicated into bits 20:12; 0 for ADD/SUB.
- out_rd  out  RD_WIDTH  head destination register.
- wb_valid  out  1  adder result valid this cycle.
- wb_rd  out  RD_WIDTH  destination for the current adder result.

Behaviour:
- Reset (synchronous): pointers, count, wb_valid, wb_rd and dec_illegal are all 0; out_valid = 0. add_type, src1, src2, immediate and out_rd read 0 (entries are cleared).
- Decode rules:
  - ADD: opcode 0110011, funct3 000, funct7 0000000.
  - SUB: opcode 0110011, funct3 000, funct7 0100000.
  - ADDI: opcode 0010011, funct3 000.
  - rd = instr[11:7].
  - Anything else is illegal.
- in_ready = (count < DEPTH). No push-through when full, even if a pop occurs that cycle.
- Accept = in_valid && in_ready.
  - Legal op: entry written at wr_ptr.
  - Illegal op: nothing stored; dec_illegal = 1 the next cycle.
- out_valid = (count != 0). Outputs are driven combinationally from the entry at rd_ptr.
- Pop = out_valid && out_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO; an op is never reordered or duplicated.
- Latency: an op accepted in cycle N is at the head in cycle N+1 at the earliest.
- Writeback tag: on pop in cycle N, wb_valid = 1 and wb_rd = popped rd in cycle N+1, aligned with the adder's registered add_value. Otherwise wb_valid = 0 and wb_rd holds its last value.
- flush: next cycle count = 0, pointers = 0, wb_valid = 0 and dec_illegal = 0. A push or pop in the flush cycle is discarded. flush takes priority over in_valid/out_ready.
- Reset mid-stream: identical to flush, plus wb_rd is cleared.
- Operand data is captured at accept. Later changes on in_rs*_data do not affect stored entries.

Optional Feature:
- Macro: INT_ISSUE_BYPASS_EN.
- Defined:
  - When count == 0, in_valid is a legal op and out_ready = 1, the decoded op drives the outputs combinationally in the same cycle and is not stored (zero-latency issue).
  - out_valid = 1 in that cycle.
  - wb_valid/wb_rd follow the normal pop rule.
  - If out_ready = 0, the op is enqueued normally.
- Undefined: minimum accept-to-issue latency is one cycle, as above.

Test Plan:
1. After reset, push ADD x3 with rs1=5, rs2=7 and out_ready=1 -> next cycle out_valid=1, add_type=00, src1=5, src2=7, out_rd=3; the cycle after, wb_valid=1, wb_rd=3.
2. ADDI x1 with imm=-1 (0xFFF) -> add_type=10, immediate=21'h1FFFFF, src2=0.
3. With out_ready=0, push 5 legal ops -> in_ready drops after 4 accepts; raising out_ready drains them in order; wb_rd sequence matches push order.
4. Simultaneous push and pop at count=2 -> count stays 2; wrap past entry 3 keeps FIFO order.
5. Push 0x00000073 (ECALL) -> dec_illegal pulses for 1 cycle, count stays 0, no wb_valid.
6. Queue holds 3 ops, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, wb_valid=0; no flushed op ever appears on the outputs.

Source files
------------

// File: rtl/int_add_issue_queue.sv
// int_add_issue_queue: issue stage in front of the integer adder.
// Decodes ADD/SUB/ADDI from decode, buffers decoded ops in a small FIFO,
// presents the head op under valid/ready and tags the adder's registered
// result with its destination register.
// Optional zero-latency bypass of an empty queue: define INT_ISSUE_BYPASS_EN.
module int_add_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  dec_illegal,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            add_type,
  output logic [DATA_WIDTH-1:0] src1,
  output logic [DATA_WIDTH-1:0] src2,
  output logic [20:0]           immediate,
  output logic [RD_WIDTH-1:0]   out_rd,
  output logic                  wb_valid,
  output logic [RD_WIDTH-1:0]   wb_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] CTRL_ADD  = 2'b00;
  localparam logic [1:0] CTRL_SUB  = 2'b01;
  localparam logic [1:0] CTRL_ADDI = 2'b10;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  // Queue storage and control state.
  logic [1:0]            type_q [DEPTH];
  logic [1:0]            type_d [DEPTH];
  logic [DATA_WIDTH-1:0] src1_q [DEPTH];
  logic [DATA_WIDTH-1:0] src1_d [DEPTH];
  logic [DATA_WIDTH-1:0] src2_q [DEPTH];
  logic [DATA_WIDTH-1:0] src2_d [DEPTH];
  logic [20:0]           imm_q  [DEPTH];
  logic [20:0]           imm_d  [DEPTH];
  logic [RD_WIDTH-1:0]   rd_q   [DEPTH];
  logic [RD_WIDTH-1:0]   rd_d   [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wb_valid_q, wb_valid_d;
  logic [RD_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic                dec_illegal_q, dec_illegal_d;

  // Decoded view of the instruction currently offered by decode.
  logic                  dec_legal;
  logic [1:0]            dec_type;
  logic [DATA_WIDTH-1:0] dec_src2;
  logic [20:0]           dec_imm;
  logic [RD_WIDTH-1:0]   dec_rd;

  logic empty;
  logic bypass;
  logic accept;
  logic push;
  logic pop;
  logic pop_queue;

  // The rs1 field is not needed here since the operand value arrives separately.
  logic unused_rs1_field;
  assign unused_rs1_field = ^in_instr[19:15];

  // Decode ADD/SUB/ADDI into adder control, second operand and immediate.
  always_comb begin
    dec_legal = 1'b0;
    dec_type  = CTRL_ADD;
    dec_src2  = in_rs2_data;
    dec_imm   = '0;
    dec_rd    = RD_WIDTH'(in_instr[11:7]);
    if (in_instr[6:0] == OP_REG && in_instr[14:12] == 3'b000) begin
      if (in_instr[31:25] == 7'b0000000) begin
        dec_legal = 1'b1;
        dec_type  = CTRL_ADD;
      end else if (in_instr[31:25] == 7'b0100000) begin
        dec_legal = 1'b1;
        dec_type  = CTRL_SUB;
      end
    end else if (in_instr[6:0] == OP_IMM && in_instr[14:12] == 3'b000) begin
      dec_legal = 1'b1;
      dec_type  = CTRL_ADDI;
      dec_src2  = '0;
      dec_imm   = {{9{in_instr[31]}}, in_instr[31:20]};
    end
  end

  // Head-of-queue outputs; zeros when nothing valid so stale entries never leak.
  always_comb begin
    empty     = (count_q == '0);
    out_valid = !empty;
    add_type  = '0;
    src1      = '0;
    src2      = '0;
    immediate = '0;
    out_rd    = '0;
    bypass    = 1'b0;
    if (!empty) begin
      add_type  = type_q[rd_ptr_q];
      src1      = src1_q[rd_ptr_q];
      src2      = src2_q[rd_ptr_q];
      immediate = imm_q[rd_ptr_q];
      out_rd    = rd_q[rd_ptr_q];
    end
`ifdef INT_ISSUE_BYPASS_EN
    bypass = empty && in_valid && dec_legal && out_ready;
    if (bypass) begin
      out_valid = 1'b1;
      add_type  = dec_type;
      src1      = in_rs1_data;
      src2      = dec_src2;
      immediate = dec_imm;
      out_rd    = dec_rd;
    end
`endif
    pop       = out_valid && out_ready;
    pop_queue = pop && !bypass;
  end

  // Next-state: enqueue, dequeue, writeback tag and illegal pulse; flush wins.
  always_comb begin
    in_ready      = (count_q < CNT_W'(DEPTH));
    accept        = in_valid && in_ready;
    push          = accept && dec_legal && !bypass;
    type_d        = type_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    imm_d         = imm_q;
    rd_d          = rd_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    dec_illegal_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        type_d[wr_ptr_q] = dec_type;
        src1_d[wr_ptr_q] = in_rs1_data;
        src2_d[wr_ptr_q] = dec_src2;
        imm_d[wr_ptr_q]  = dec_imm;
        rd_d[wr_ptr_q]   = dec_rd;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop_queue) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_queue);
      if (pop) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = out_rd;
      end
      dec_illegal_d = accept && !dec_legal;
    end
  end

  // State registers with synchronous reset that also clears the entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= '0;
        src1_q[i] <= '0;
        src2_q[i] <= '0;
        imm_q[i]  <= '0;
        rd_q[i]   <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      dec_illegal_q <= 1'b0;
    end else begin
      type_q        <= type_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      imm_q         <= imm_d;
      rd_q          <= rd_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      dec_illegal_q <= dec_illegal_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign dec_illegal = dec_illegal_q;

endmodule

// File: tb/tb_int_add_issue_queue.sv
// tb_int_add_issue_queue: directed stimulus against a queue-based reference
// model, compared on every falling edge, plus a few literal expectations.
module tb_int_add_issue_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        dec_illegal;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  add_type;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [20:0] immediate;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int_add_issue_queue #(.DATA_WIDTH(32), .DEPTH(4), .RD_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .dec_illegal(dec_illegal), .out_valid(out_valid), .out_ready(out_ready),
    .add_type(add_type), .src1(src1), .src2(src2), .immediate(immediate),
    .out_rd(out_rd), .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [20:0] imm;
    logic [4:0]  rd;
  } op_t;

  // Reference model state: queue contents plus registered side outputs.
  op_t        mq[$];
  logic       m_wb_valid = 1'b0;
  logic [4:0] m_wb_rd = '0;
  logic       m_illegal = 1'b0;

  function automatic bit modelDecode(input logic [31:0] ins, input logic [31:0] r1,
                                     input logic [31:0] r2, output op_t o);
    logic signed [20:0] sx;
    o.rd  = ins[11:7];
    o.s1  = r1;
    o.s2  = r2;
    o.imm = '0;
    o.t   = 2'b00;
    if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h00) return 1'b1;
    if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h20) begin
      o.t = 2'b01;
      return 1'b1;
    end
    if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
      sx    = 21'($signed(ins[31:20]));
      o.t   = 2'b10;
      o.s2  = '0;
      o.imm = sx;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rd);
    return {imm, 5'd1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model one clock.
  always @(negedge clk) begin
    if (checking) begin
      op_t dop;
      op_t head;
      bit  legal;
      bit  byp;
      bit  exp_valid;
      bit  acc;
      bit  pop;
      legal = modelDecode(in_instr, in_rs1_data, in_rs2_data, dop);
      byp = 1'b0;
`ifdef INT_ISSUE_BYPASS_EN
      byp = (mq.size() == 0) && in_valid && legal && out_ready;
`endif
      head = '{2'b00, 32'd0, 32'd0, 21'd0, 5'd0};
      if (byp) head = dop;
      else if (mq.size() != 0) head = mq[0];
      exp_valid = byp || (mq.size() != 0);
      checkOutput("in_ready", 32'(in_ready), 32'(mq.size() < 4));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("add_type", 32'(add_type), 32'(head.t));
      checkOutput("src1", src1, head.s1);
      checkOutput("src2", src2, head.s2);
      checkOutput("immediate", 32'(immediate), 32'(head.imm));
      checkOutput("out_rd", 32'(out_rd), 32'(head.rd));
      checkOutput("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
      checkOutput("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
      checkOutput("dec_illegal", 32'(dec_illegal), 32'(m_illegal));
      if (reset) begin
        mq.delete();
        m_wb_valid = 1'b0;
        m_wb_rd    = '0;
        m_illegal  = 1'b0;
      end else if (flush) begin
        mq.delete();
        m_wb_valid = 1'b0;
        m_illegal  = 1'b0;
      end else begin
        acc = in_valid && (mq.size() < 4);
        pop = exp_valid && out_ready;
        m_wb_valid = pop;
        if (pop) begin
          m_wb_rd = head.rd;
          if (!byp) void'(mq.pop_front());
        end
        m_illegal = acc && !legal;
        if (acc && legal && !byp) mq.push_back(dop);
      end
    end
  end

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic ordy, input logic fl, input logic rst);
    @(posedge clk);
    #2;
    in_valid    = v;
    in_instr    = ins;
    in_rs1_data = r1;
    in_rs2_data = r2;
    out_ready   = ordy;
    flush       = fl;
    reset       = rst;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    reset    = 1'b0;
    checking = 1'b1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset wb_rd", 32'(wb_rd), 32'd0);

    // ADD x3 = 5 + 7, then watch it issue and write back.
    applyStimulus(1'b1, encR(7'h00, 5'd3), 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1 out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1 add_type", 32'(add_type), 32'd0);
    checkOutput("t1 src1", src1, 32'd5);
    checkOutput("t1 src2", src2, 32'd7);
    checkOutput("t1 out_rd", 32'(out_rd), 32'd3);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1 wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("t1 wb_rd", 32'(wb_rd), 32'd3);

    // ADDI x1, imm -1; operand change after accept must not matter.
    applyStimulus(1'b1, 32'hFFF00093, 32'd100, 32'd55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 add_type", 32'(add_type), 32'd2);
    checkOutput("t2 immediate", 32'(immediate), 32'h1FFFFF);
    checkOutput("t2 src2", src2, 32'd0);
    checkOutput("t2 src1", src1, 32'd100);
    idle(1'b1, 2);

    // Fill with ready low: five offers, fifth held until space opens.
    applyStimulus(1'b1, encR(7'h00, 5'd4), 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h20, 5'd5), 32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encI(12'h7FF, 5'd6), 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encI(12'h800, 5'd7), 32'd8, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h00, 5'd8), 32'd11, 32'd12, 1'b0, 1'b0, 1'b0);
    checkOutput("t3 full in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, encR(7'h00, 5'd8), 32'd11, 32'd12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h00, 5'd8), 32'd11, 32'd12, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h00, 5'd8), 32'd11, 32'd12, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 6);

    // Steady push+pop at count 2 across pointer wrap.
    applyStimulus(1'b1, encR(7'h00, 5'd10), 32'd10, 32'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h20, 5'd11), 32'd11, 32'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, encI(12'(i), 5'(12 + i)), 32'(20 + i), 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 4);

    // ECALL and a SLL: illegal, nothing stored.
    applyStimulus(1'b1, 32'h00000073, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5 dec_illegal", 32'(dec_illegal), 32'd1);
    checkOutput("t5 out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 32'h002091B3, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);

    // Three queued ops, then flush alongside a new offer and ready.
    applyStimulus(1'b1, encR(7'h00, 5'd20), 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h00, 5'd21), 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h00, 5'd22), 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h00, 5'd23), 32'd4, 32'd4, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6 out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6 in_ready", 32'(in_ready), 32'd1);
    checkOutput("t6 wb_valid", 32'(wb_valid), 32'd0);
    idle(1'b1, 3);

    // Reset mid-stream clears wb_rd too.
    applyStimulus(1'b1, encR(7'h00, 5'd25), 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, encR(7'h00, 5'd26), 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset2 wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("reset2 out_valid", 32'(out_valid), 32'd0);
    idle(1'b1, 2);

    @(posedge clk);
    #2;
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
